io_responder: RTL and testbench

//  Memory-mapped peripheral at the far end of the Risc16 io_* bus. Decodes io_address against a

---
 rtl/io_map_pkg.sv | 20 ++
 rtl/io_fifo.sv | 56 +++++
 rtl/io_responder.sv | 149 ++++++++++++++
 tb/tb_io_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Shared register map for the io_responder peripheral: window base, word offsets
// and STATUS bit positions.
package io_map_pkg;

    localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;

    localparam logic [2:0] IO_OFS_LED    = 3'd0;
    localparam logic [2:0] IO_OFS_SW     = 3'd1;
    localparam logic [2:0] IO_OFS_TXDATA = 3'd2;
    localparam logic [2:0] IO_OFS_STATUS = 3'd3;
    localparam logic [2:0] IO_OFS_TIMER  = 3'd4;
    localparam logic [2:0] IO_OFS_TFLAG  = 3'd5;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_TFLAG     = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 4;

endpackage

// File: rtl/io_fifo.sv
// Power-of-two circular FIFO with asynchronous pointer reset; head reads 0 while empty.
module io_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/io_responder.sv
// Memory-mapped peripheral on the Risc16 io_* bus: LED, switches, TX FIFO, STATUS.
// Define IO_TIMER_EN to build the compare timer (TIMER/TFLAG registers).
module io_responder
    import io_map_pkg::*;
#(
    parameter logic [15:0] IO_BASE    = IO_BASE_DEFAULT,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] io_address,
    input  logic [15:0] io_write_value,
    input  logic        io_write_en,
    input  logic        io_read_en,
    output logic [15:0] io_read_value,
    output logic [15:0] led_out,
    input  logic [15:0] sw_in,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]   rel;
    logic          in_window;
    logic [2:0]    ofs;
    logic          wr_hit;
    logic          led_wr;
    logic          push_req;
    logic          status_wr;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] fifo_count;
    logic [4:0]    count_ext;
    logic [3:0]    count4;
    logic [15:0]   head;
    logic          ovf;
    logic          tflag;
    logic [15:0]   timer_value;
    logic [15:0]   sw_meta;
    logic [15:0]   sw_sync;
    logic [15:0]   status;

    // Window test by subtraction so IO_BASE need not be 8-word aligned.
    assign rel       = io_address - IO_BASE;
    assign in_window = (rel < 16'd8);
    assign ofs       = rel[2:0];

    assign wr_hit    = io_write_en && in_window;
    assign led_wr    = wr_hit && (ofs == IO_OFS_LED);
    assign push_req  = wr_hit && (ofs == IO_OFS_TXDATA);
    assign status_wr = wr_hit && (ofs == IO_OFS_STATUS);

    // TX handshake: the head word transfers on a rising edge where tx_valid and
    // tx_ready are both high; tx_valid is simply "FIFO not empty" and never waits on tx_ready.
    assign pop      = tx_valid && tx_ready;
    assign tx_valid = !empty;
    assign tx_data  = head;

    io_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (io_write_value),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count),
        .head      (head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_out <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
            ovf     <= 1'b0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            if (led_wr) led_out <= io_write_value;
            if (push_req && full && !pop) ovf <= 1'b1;
            else if (status_wr)           ovf <= 1'b0;
        end
    end

`ifdef IO_TIMER_EN
    logic [15:0] counter;
    logic [15:0] compare;
    logic        timer_wr;
    logic        tflag_wr;

    assign timer_wr = wr_hit && (ofs == IO_OFS_TIMER);
    assign tflag_wr = wr_hit && (ofs == IO_OFS_TFLAG);

    // A TIMER load suppresses that edge's match; a match beats a TFLAG clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= '0;
            compare <= 16'hFFFF;
            tflag   <= 1'b0;
        end else if (timer_wr) begin
            counter <= '0;
            compare <= io_write_value;
        end else begin
            counter <= counter + 16'd1;
            if (counter == compare) tflag <= 1'b1;
            else if (tflag_wr)      tflag <= 1'b0;
        end
    end

    assign timer_value = counter;
`else
    assign tflag       = 1'b0;
    assign timer_value = 16'h0000;
`endif

    // The 4-bit count field saturates so a 16-deep full FIFO reads as 15.
    assign count_ext = 5'(fifo_count);
    assign count4    = (count_ext > 5'd15) ? 4'hF : count_ext[3:0];

    always_comb begin
        status                          = '0;
        status[ST_EMPTY]                = empty;
        status[ST_FULL]                 = full;
        status[ST_TFLAG]                = tflag;
        status[ST_OVF]                  = ovf;
        status[ST_COUNT_LSB +: 4]       = count4;
    end

    always_comb begin
        io_read_value = 16'h0000;
        if (io_read_en && in_window) begin
            case (ofs)
                IO_OFS_LED:    io_read_value = led_out;
                IO_OFS_SW:     io_read_value = sw_sync;
                IO_OFS_STATUS: io_read_value = status;
                IO_OFS_TIMER:  io_read_value = timer_value;
                default:       io_read_value = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// Directed self-checking bench for io_responder; the timer section follows IO_TIMER_EN.
module tb_io_responder;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk;
    logic        reset;
    logic [15:0] io_address;
    logic [15:0] io_write_value;
    logic        io_write_en;
    logic        io_read_en;
    logic [15:0] io_read_value;
    logic [15:0] led_out;
    logic [15:0] sw_in;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int vec_cnt;
    int miscompares;
    logic [15:0] exp_q[$];
    logic [15:0] rd;

    io_responder dut (
        .clk            (clk),
        .reset          (reset),
        .io_address     (io_address),
        .io_write_value (io_write_value),
        .io_write_en    (io_write_en),
        .io_read_en     (io_read_en),
        .io_read_value  (io_read_value),
        .led_out        (led_out),
        .sw_in          (sw_in),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        io_address     = addr;
        io_write_value = data;
        io_write_en    = 1'b1;
        @(posedge clk);
        #1;
        io_write_en    = 1'b0;
    endtask

    // Combinational read: no clock edge consumed.
    task automatic peek(input logic [15:0] addr, output logic [15:0] data);
        io_address = addr;
        io_read_en = 1'b1;
        #1;
        data       = io_read_value;
        io_read_en = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            #1;
            if (!tx_valid) break;
            if (exp_q.size() == 0) check("drain_extra", {15'b0, tx_valid}, 16'h0000);
            else                   check("drain_word", tx_data, exp_q.pop_front());
            @(negedge clk);
        end
        tx_ready = 1'b0;
        check("drain_left", 16'(exp_q.size()), 16'h0000);
        check("drain_valid", {15'b0, tx_valid}, 16'h0000);
        exp_q.delete();
    endtask

    initial begin
        vec_cnt        = 0;
        miscompares    = 0;
        reset          = 1'b1;
        io_address     = 16'h0000;
        io_write_value = 16'h0000;
        io_write_en    = 1'b0;
        io_read_en     = 1'b0;
        sw_in          = 16'h1234;
        tx_ready       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // reset state
        #1;
        check("rst_led", led_out, 16'h0000);
        check("rst_valid", {15'b0, tx_valid}, 16'h0000);
        check("rst_txdata", tx_data, 16'h0000);
        peek(BASE + 16'd0, rd); check("rst_rd_led", rd, 16'h0000);
        peek(BASE + 16'd3, rd); check("rst_status", rd, 16'h0001);

        // LED, switches, window decode
        bus_write(BASE + 16'd0, 16'hA5A5);
        check("led_out", led_out, 16'hA5A5);
        peek(BASE + 16'd0, rd); check("rd_led", rd, 16'hA5A5);
        peek(16'hFF08, rd);     check("rd_outside", rd, 16'h0000);
        io_address = BASE; #1;  check("rd_no_en", io_read_value, 16'h0000);
        peek(BASE + 16'd1, rd); check("rd_sw", rd, 16'h1234);
        bus_write(BASE + 16'd1, 16'hFFFF);
        peek(BASE + 16'd1, rd); check("sw_wr_ignored", rd, 16'h1234);
        peek(BASE + 16'd2, rd); check("rd_txdata", rd, 16'h0000);
        peek(BASE + 16'd6, rd); check("rd_rsvd", rd, 16'h0000);

        // write and read same cycle: read sees pre-edge value
        @(negedge clk);
        io_address = BASE; io_write_value = 16'h5A5A; io_write_en = 1'b1; io_read_en = 1'b1;
        #1; check("rw_pre", io_read_value, 16'hA5A5);
        @(posedge clk); #1;
        io_write_en = 1'b0; io_read_en = 1'b0;
        peek(BASE, rd); check("rw_post", rd, 16'h5A5A);

        // overflow: 9 pushes into an 8-deep FIFO
        for (int i = 1; i <= 9; i++) begin
            bus_write(BASE + 16'd2, 16'(i));
            if (i <= 8) exp_q.push_back(16'(i));
        end
        peek(BASE + 16'd3, rd); check("ovf_status", rd, 16'h008A);
        check("ovf_head", tx_data, 16'h0001);
        drain(40);
        peek(BASE + 16'd3, rd); check("ovf_sticky", rd, 16'h0009);
        bus_write(BASE + 16'd3, 16'h1234);
        peek(BASE + 16'd3, rd); check("ovf_clear", rd, 16'h0001);

        // push and pop on the same edge while full
        for (int i = 0; i < 8; i++) begin
            bus_write(BASE + 16'd2, 16'h0011 + 16'(i));
            exp_q.push_back(16'h0011 + 16'(i));
        end
        @(negedge clk);
        io_address = BASE + 16'd2; io_write_value = 16'h0042; io_write_en = 1'b1; tx_ready = 1'b1;
        #1; check("ovl_head", tx_data, exp_q.pop_front());
        exp_q.push_back(16'h0042);
        @(posedge clk); #1;
        io_write_en = 1'b0; tx_ready = 1'b0;
        peek(BASE + 16'd3, rd); check("ovl_status", rd, 16'h0082);
        drain(40);

        // timer
`ifdef IO_TIMER_EN
        bus_write(BASE + 16'd4, 16'd10);
        peek(BASE + 16'd4, rd); check("tmr_load", rd, 16'h0000);
        repeat (10) @(posedge clk);
        #1;
        peek(BASE + 16'd4, rd); check("tmr_count10", rd, 16'd10);
        peek(BASE + 16'd3, rd); check("tflag_before", rd, 16'h0001);
        @(posedge clk); #1;
        peek(BASE + 16'd3, rd); check("tflag_set", rd, 16'h0005);
        peek(BASE + 16'd5, rd); check("rd_tflag_reg", rd, 16'h0000);
        bus_write(BASE + 16'd5, 16'h0000);
        peek(BASE + 16'd3, rd); check("tflag_clear", rd, 16'h0001);
`else
        bus_write(BASE + 16'd4, 16'd10);
        repeat (20) @(posedge clk);
        #1;
        peek(BASE + 16'd4, rd); check("tmr_absent", rd, 16'h0000);
        peek(BASE + 16'd3, rd); check("tflag_absent", rd, 16'h0001);
`endif

        // reset during drain
        for (int i = 0; i < 3; i++) bus_write(BASE + 16'd2, 16'h0100 + 16'(i));
        check("pre_rst_valid", {15'b0, tx_valid}, 16'h0001);
        @(negedge clk);
        tx_ready = 1'b1;
        reset    = 1'b1;
        #1;
        check("async_valid", {15'b0, tx_valid}, 16'h0000);
        check("async_txdata", tx_data, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        tx_ready = 1'b0;
        #1;
        peek(BASE + 16'd3, rd); check("post_rst_status", rd, 16'h0001);
        check("post_rst_led", led_out, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
